// File: rtl/alu_issue_unit.sv
// Registered issue front end for the 32-bit combinational ALU with an in-order response buffer.
// Optional feature: define ALU_ISSUE_OPCHECK_EN to reject opcode 7 with resp_err instead of issuing it.
module alu_issue_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       alu_s,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic             resp_cout,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = 36 + TAG_W;
  localparam logic [2:0] OpRsvd = 3'd7;

  // Issue stage
  logic             exec_v_q, exec_v_d;
  logic             exec_err_q, exec_err_d;
  logic [TAG_W-1:0] exec_tag_q, exec_tag_d;
  logic [2:0]       alu_s_q, alu_s_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;

  // Response buffer
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic             is_rsvd;
  logic [PW+1:0]    occ;
  logic [EW-1:0]    cap_entry;

  assign push       = exec_v_q;
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid & resp_ready;
  assign is_rsvd    = (req_op == OpRsvd);

  // Counts the capture already in flight so the buffer can never overflow.
  assign occ       = {1'b0, count_q} + (PW+2)'(exec_v_q) - (PW+2)'(pop);
  assign req_ready = !reset && (occ < (PW+2)'(DEPTH));
  assign accept    = req_valid & req_ready;

  always_comb begin
    exec_v_d   = accept;
    exec_err_d = exec_err_q;
    exec_tag_d = exec_tag_q;
    alu_s_d    = alu_s_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    if (accept) begin
      exec_tag_d = req_tag;
      alu_a_d    = req_a;
      alu_b_d    = req_b;
`ifdef ALU_ISSUE_OPCHECK_EN
      exec_err_d = is_rsvd;
      if (!is_rsvd) begin
        alu_s_d = req_op;
      end
`else
      exec_err_d = 1'b0;
      alu_s_d    = req_op;
`endif
    end
  end

  always_comb begin
    cap_entry = {exec_err_q, exec_tag_q, alu_cout, alu_overflow, alu_zero, alu_out};
`ifdef ALU_ISSUE_OPCHECK_EN
    if (exec_err_q) begin
      cap_entry = {1'b1, exec_tag_q, 35'd0};
    end
`else
    if (is_rsvd && exec_err_q) begin
      cap_entry = '0;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_v_q   <= 1'b0;
      exec_err_q <= 1'b0;
      exec_tag_q <= '0;
      alu_s_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
    end else begin
      exec_v_q   <= exec_v_d;
      exec_err_q <= exec_err_d;
      exec_tag_q <= exec_tag_d;
      alu_s_q    <= alu_s_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

  // Buffer contents are cleared too so every response field reads 0 while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= cap_entry;
      end
    end
  end

  assign alu_s = alu_s_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign {resp_err, resp_tag, resp_cout, resp_overflow, resp_zero, resp_data} = mem_q[rd_ptr_q];
  assign busy  = exec_v_q | resp_valid;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a behavioural ALU on the alu_* side.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic [2:0]  alu_s;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero, alu_overflow, alu_cout;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_zero, resp_overflow, resp_cout;
  logic [3:0]  resp_tag;
  logic        resp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DEPTH(2), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_cout(alu_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_overflow(resp_overflow), .resp_cout(resp_cout),
    .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
  );

  function automatic logic [34:0] alu_model(logic [2:0] s, logic [31:0] a, logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (s)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = w[31:0];
        c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = {31'd0, $signed(a) < $signed(b)};
      3'd4: r = a << b[4:0];
      3'd5: r = a >> b[4:0];
      3'd6: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'hDEAD_0007;
    endcase
    return {c, v, (r == 32'd0), r};
  endfunction

  always_comb {alu_cout, alu_overflow, alu_zero, alu_out} = alu_model(alu_s, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    int n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    #1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("accept_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Waits for a response with resp_ready high, samples it and pops it.
  task automatic get_resp(output logic [31:0] d, output logic [3:0] fl, output logic [3:0] tg);
    int n = 0;
    resp_ready = 1'b1;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("resp_timeout", 32'd0, 32'd1);
    d  = resp_data;
    fl = {resp_err, resp_cout, resp_overflow, resp_zero};
    tg = resp_tag;
    tick();
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] d;
    logic [3:0]  fl, tg;
    issue(op, a, b, 4'd5);
    get_resp(d, fl, tg);
    check(name, d, exp);
    check({name, "_tag"}, {28'd0, tg}, 32'd5);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  fl, tg;
    int          acc;

    reset = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    resp_ready = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Single ADD with cycle-exact latency
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd7; req_tag = 4'd3;
    tick();
    req_valid = 1'b0;
    check("add_alu_a", alu_a, 32'd5);
    check("add_resp_early", {31'd0, resp_valid}, 32'd0);
    check("add_busy", {31'd0, busy}, 32'd1);
    tick();
    check("add_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("add_data", resp_data, 32'd12);
    check("add_zero", {31'd0, resp_zero}, 32'd0);
    check("add_tag", {28'd0, resp_tag}, 32'd3);
    tick();
    check("add_one_pulse", {31'd0, resp_valid}, 32'd0);
    check("add_idle", {31'd0, busy}, 32'd0);

    // SUB zero and signed overflow
    issue(3'd1, 32'h1234, 32'h1234, 4'd1);
    get_resp(d, fl, tg);
    check("sub_zero_data", d, 32'd0);
    check("sub_zero_flag", {31'd0, fl[0]}, 32'd1);
    issue(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    get_resp(d, fl, tg);
    check("sub_ovf_data", d, 32'h8000_0000);
    check("sub_ovf_flag", {31'd0, fl[1]}, 32'd1);

    run_op("xor", 3'd2, 32'hF0F0_0000, 32'h0FF0_0000, 32'hFF00_0000);
    run_op("slt", 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_op("sll", 3'd4, 32'd1, 32'd31, 32'h8000_0000);
    run_op("srl", 3'd5, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_op("sra", 3'd6, 32'h8000_0000, 32'd4, 32'hF800_0000);

    // Back-to-back throughput, responses two cycles behind requests
    resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'(c) * 32'd16; req_b = 32'd1;
        req_tag = 4'(c);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c < 8) check("tput_ready", {31'd0, req_ready}, 32'd1);
      if (c >= 2) begin
        check("tput_valid", {31'd0, resp_valid}, 32'd1);
        check("tput_tag", {28'd0, resp_tag}, 32'(c - 2));
        check("tput_data", resp_data, 32'(c - 2) * 32'd16 + 32'd1);
      end
      tick();
    end
    check("tput_drained", {31'd0, resp_valid}, 32'd0);

    // Backpressure: only DEPTH accepted, then pop-and-accept in one cycle
    resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'd100 + 32'(acc); req_b = 32'd0;
      req_tag = 4'd8 + 4'(acc);
      #1;
      if (req_ready) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    check("bp_head_tag", {28'd0, resp_tag}, 32'd8);
    check("bp_head_data", resp_data, 32'd100);
    resp_ready = 1'b1;
    #1;
    check("bp_pop_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_d1_tag", {28'd0, resp_tag}, 32'd9);
    check("bp_d1_data", resp_data, 32'd101);
    tick();
    check("bp_d2_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_d2_tag", {28'd0, resp_tag}, 32'd10);
    check("bp_d2_data", resp_data, 32'd102);
    tick();
    check("bp_empty", {31'd0, resp_valid}, 32'd0);
    check("bp_idle", {31'd0, busy}, 32'd0);

    // Reserved opcode after an XOR leaves alu_s at 2
    run_op("pre_rsvd_xor", 3'd2, 32'd3, 32'd5, 32'd6);
    issue(3'd7, 32'd1, 32'd1, 4'd6);
`ifdef ALU_ISSUE_OPCHECK_EN
    check("rsvd_alu_s", {29'd0, alu_s}, 32'd2);
    get_resp(d, fl, tg);
    check("rsvd_err", {31'd0, fl[3]}, 32'd1);
    check("rsvd_data", d, 32'd0);
    check("rsvd_flags", {29'd0, fl[2:0]}, 32'd0);
`else
    check("rsvd_alu_s", {29'd0, alu_s}, 32'd7);
    get_resp(d, fl, tg);
    check("rsvd_err", {31'd0, fl[3]}, 32'd0);
    check("rsvd_data", d, 32'hDEAD_0007);
`endif
    check("rsvd_tag", {28'd0, tg}, 32'd6);

    // Reset with one entry buffered and one op in flight
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd1; req_b = 32'd1; req_tag = 4'd1;
    tick();
    req_a = 32'd3; req_b = 32'd3; req_tag = 4'd2;
    tick();
    req_valid = 1'b0;
    check("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("after_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("after_rst_busy", {31'd0, busy}, 32'd0);
    check("after_rst_ready", {31'd0, req_ready}, 32'd1);
    run_op("after_rst_add", 3'd0, 32'd2, 32'd2, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end that accepts ALU commands over a valid/ready request channel, registers and issues them to the 32-bit combinational ALU, captures the result and flags one cycle later, and returns them in order over a valid/ready response channel through a small buffer. It is the requesting side of the ALU's `S`/`A`/`B` → `out`/`Zero`/`Overflow`/`Cout` interface. It is the block the datapath controller talks to instead of driving the ALU directly.

## Interface
Parameters:
- DEPTH, 2, response buffer entries; power of two, ≥2
- TAG_W, 4, width of the opaque request tag carried to the response

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  command present
- req_ready  out  1  unit accepts the command this cycle
- req_op  in  3  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 SLL, 5 SRL, 6 SRA, 7 reserved
- req_a, req_b  in  32  operands
- req_tag  in  TAG_W  opaque tag
- alu_s  out  3  registered opcode to the ALU select
- alu_a, alu_b  out  32  registered operands to the ALU
- alu_out  in  32  ALU result
- alu_zero, alu_overflow, alu_cout  in  1  ALU flags
- resp_valid  out  1  head of the response buffer is valid
- resp_ready  in  1  consumer takes the head this cycle
- resp_data  out  32  result
- resp_zero, resp_overflow, resp_cout  out  1  captured flags
- resp_tag  out  TAG_W  tag of the originating request
- resp_err  out  1  reserved opcode rejected (see Configuration)
- busy  out  1  an operation is in flight or the buffer is non-empty

## Operation
- Accept: on `req_valid && req_ready` at edge N, latch the op, operands and tag into the issue stage. Set `exec_v=1`. Drive `alu_s`, `alu_a` and `alu_b` from the issue registers.
- Capture: at edge N+1, if `exec_v`, write `{alu_out, flags, tag, err}` into the buffer tail.
  - `exec_v` clears unless a new request is accepted at the same edge.
- The issue registers hold their last values while idle. They do not return to zero.
- Occupancy rule: `req_ready = (count + exec_v − pop) < DEPTH`, where `pop = resp_valid && resp_ready`.
  - This path is combinational from `resp_ready`.
  - The buffer must never overflow. No capture is ever dropped.
- Response: `resp_valid = (count != 0)`. Response fields show the buffer head.
  - A pop advances the head at the edge.
  - Response fields stay stable while `resp_valid && !resp_ready`.
- Simultaneous capture and pop: count is unchanged and both pointers advance. This applies at full and at empty.
  - A capture into an empty buffer appears on `resp_valid` the cycle after capture. There is no bypass.
- Ordering: responses leave strictly in acceptance order.
- Pointers are `log2(DEPTH)` bits wide and wrap modulo DEPTH. `count` is `log2(DEPTH)+1` bits wide.
- `busy = exec_v || count != 0`.
- Reset (async, any time, including mid-operation): `exec_v=0`, `count=0`, and both pointers 0. In-flight and buffered results are discarded.
  - All outputs read 0 while reset is high, including `req_ready`.
  - After release, `req_ready=1`.

## Timing
- Latency: request accepted at edge N gives `resp_valid` high in the cycle after edge N+1, assuming no backpressure.
- Throughput: one command per cycle sustained while `resp_ready=1`.
- Under full backpressure, `DEPTH` commands are accepted. `req_ready` then drops to 0 until a pop occurs.
- The ALU has a full cycle to settle. Its inputs change only at an acceptance edge.

## Configuration
- `ALU_ISSUE_OPCHECK_EN` defined:
  - Opcode 7 is accepted normally, but `alu_s` is not updated for that command.
  - The captured entry has `resp_err=1`, `resp_data=0`, and all flags 0.
  - Latency and ordering are unchanged.
- Not defined:
  - Opcode 7 is issued to the ALU like any other opcode, and whatever the ALU returns is captured.
  - `resp_err` is tied to 0.

## Test plan
- Single ADD: A=5, B=7, tag=3, `resp_ready=1` → two cycles later `resp_data=12`, `resp_zero=0`, `resp_tag=3`, one `resp_valid` pulse.
- SUB producing zero: A=B=0x1234 → `resp_data=0`, `resp_zero=1`. Then A=0x7FFFFFFF, B=0xFFFFFFFF, SUB → `resp_overflow=1`.
- Back-to-back throughput: 8 consecutive ADDs with tags 0..7 and `resp_ready=1` → `req_ready` stays 1 and responses arrive one per cycle with tags 0..7 in order.
- Backpressure: `resp_ready=0` with 4 requests offered at DEPTH=2 → exactly 2 accepted, then `req_ready=0` and `busy=1`. Assert `resp_ready=1` and `req_ready=1` in that same cycle (pop-and-accept). Responses drain in order with no loss or duplication.
- Opcode 7 (A=1, B=1): with `ALU_ISSUE_OPCHECK_EN`, `resp_err=1`, `resp_data=0`, and `alu_s` keeps its previous value. Without it, `alu_s=7` and `resp_err=0`.
- Reset mid-operation: assert reset for one cycle while an op is in flight and 1 entry is buffered → outputs immediately 0. After release, `resp_valid=0`, `busy=0`, `req_ready=1`, and the next ADD of 2+2 returns 4.
